// File: rtl/bcd_down4.sv
// bcd_down4: four-digit BCD down-counter with load/start/stop sequencing.
// Counts down by one on each x-qualified edge while running. It stops in DONE
// when the count reaches zero and stays there until the next load.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | count held; waiting for start (x ignored)
// RUN   | counting down one BCD step per clock edge with x high
// DONE  | count reached zero; only load or reset leave this state

module bcd_down4 (
    input  logic        clk,
    input  logic        reset,
    input  logic        x,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        start,
    input  logic        stop,
    output logic [15:0] bcd_out,
    output logic        zero,
    output logic        done,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic [15:0] count_q;
    logic        done_q;
    logic        busy_q;

    logic [15:0] load_sat_d;
    logic [15:0] count_dec_d;
    logic        count_is_zero;
    logic        count_is_one;

    // Clamp each incoming nibble to 9 so the count only ever holds legal BCD.
    always_comb begin
        load_sat_d = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            if (load_val[4*i +: 4] > 4'd9) begin
                load_sat_d[4*i +: 4] = 4'd9;
            end else begin
                load_sat_d[4*i +: 4] = load_val[4*i +: 4];
            end
        end
    end

    // BCD decrement: a borrow ripples up through digits that are zero (they wrap to 9),
    // and the first nonzero digit it reaches is decremented.
    always_comb begin
        logic borrow;
        count_dec_d = count_q;
        borrow      = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (borrow) begin
                if (count_q[4*i +: 4] == 4'd0) begin
                    count_dec_d[4*i +: 4] = 4'd9;
                end else begin
                    count_dec_d[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
                    borrow                = 1'b0;
                end
            end
        end
    end

    assign count_is_zero = (count_q == 16'h0000);
    assign count_is_one  = (count_q == 16'h0001);

    // Sequencing FSM with registered count and status outputs.
    // Edge priority is load > stop > start > x.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            count_q <= 16'h0000;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else if (load) begin
            state_q <= S_IDLE;
            count_q <= load_sat_d;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (count_is_zero) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= S_RUN;
                            done_q  <= 1'b0;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (x) begin
                        if (count_is_one || count_is_zero) begin
                            // The final step lands on 0000 and finishes on the same edge.
                            // A zero count here would be a stray case; finish without wrapping.
                            count_q <= 16'h0000;
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            count_q <= count_dec_d;
                        end
                    end
                end
                S_DONE: begin
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bcd_out = count_q;
    assign zero    = count_is_zero;
    assign done    = done_q;
    assign busy    = busy_q;

endmodule

// File: doc/bcd_down4.md
BCD_DOWN4 -- requirements
Module: bcd_down4

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named as the codebase does (clk, reset):
- clk  input  1  rising-edge clock for all state
- reset  input  1  asynchronous, active-low reset
REQ-002 x  input  1  decrement request; one BCD decrement per clock edge while high in RUN.
REQ-003 load  input  1  synchronous load strobe.
REQ-004 load_val  input  16  preset value, 4 BCD digits, [15:12] most significant.
REQ-005 start  input  1  start strobe; begins countdown.
REQ-006 stop  input  1  stop strobe; pauses countdown and holds the count.
REQ-007 bcd_out  output  16  current count, 4 BCD digits, [3:0] least significant.
REQ-008 zero  output  1  high when bcd_out == 16'h0000 (combinational from the count register).
REQ-009 done  output  1  registered; high while in state DONE.
REQ-010 busy  output  1  registered; high while in state RUN.

Function
REQ-011 The block SHALL implement a 3-state FSM: IDLE, RUN, DONE.
REQ-012 Control priority at each edge SHALL be load > stop > start > x.
REQ-013 load=1 in any state: each nibble SHALL be loaded as min(load_val nibble, 9); state SHALL go to IDLE; done and busy SHALL go to 0.
REQ-014 IDLE, start=1, count != 0: the FSM SHALL go to RUN. The count SHALL be unchanged on that edge.
REQ-015 IDLE, start=1, count == 0: the FSM SHALL go directly to DONE.
REQ-016 RUN, stop=1: the FSM SHALL go to IDLE and the count SHALL be held.
REQ-017 RUN, x=1, count != 0: the count SHALL decrement by 1 in BCD:
- digit 0 decrements every time;
- digit i decrements only if digits 0..i-1 are all 0;
- a decrementing digit at 0 wraps to 9.
REQ-018 RUN, x=1, count == 0001: the count SHALL become 0000 and the FSM SHALL go to DONE on the same edge.
REQ-019 RUN, x=0: the count and state SHALL be held.
REQ-020 x SHALL be ignored in IDLE and DONE; the count SHALL never change there except by load.
REQ-021 DONE: start and stop SHALL be ignored; DONE SHALL be exited only by load or reset.
REQ-022 Latency: bcd_out, done and busy SHALL reflect an edge's action immediately after that edge (1-cycle registered); zero SHALL follow bcd_out combinationally.
REQ-023 The count SHALL never underflow below 0000 or wrap to 9999.
REQ-024 Every digit SHALL remain in 0..9 at all times.

Reset
REQ-025 reset=0 SHALL immediately, independent of clk, force:
- count = 16'h0000 (so zero = 1);
- state = IDLE;
- done = 0, busy = 0.
REQ-026 Reset asserted mid-RUN SHALL abandon the countdown; after release the block SHALL wait in IDLE for load/start.
REQ-027 The first clock edge after reset release SHALL be processed normally.

Verification
REQ-028 Reset, load_val=16'h0012, start, x held high -> bcd_out sequence 0012, 0011, 0010, 0009, ... 0001, 0000; done=1 and busy=0 on the edge giving 0000; bcd_out then stays 0000.
REQ-029 Load 16'h1000, start, one x pulse -> bcd_out=0999, busy=1, done=0.
REQ-030 Load 16'h00AF -> bcd_out=0099, confirming nibble clamp.
REQ-031 Load 0005, start, x for 2 edges, stop, x for 3 edges -> bcd_out=0003, state IDLE; then start plus 3 x edges -> 0000, done=1.
REQ-032 load and start asserted on the same edge with load_val=0042 -> bcd_out=0042, state IDLE, busy=0; load 0000 then start -> done=1 next edge.
REQ-033 Load 0300, start, x for 50 edges, then reset pulse low for half a cycle -> bcd_out=0000, busy=0, done=0 before the next clk edge.
